riscv_mem_arbiter: RTL and testbench

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

---
 rtl/riscv_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// Two-port (fetch / data) round-robin arbiter in front of a single-port synchronous memory.
// Grants are combinational; responses follow exactly one cycle after the grant.
module riscv_mem_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       conflict_cnt
);

  logic prio_d;
  logic d_misal;
  logic if_pend;
  logic d_pend;
  logic d_load;
  logic d_err_q;

  assign d_misal = (d_addr[1:0] != 2'b00);

  // Round-robin grant; prio_d set means the data port wins a tie.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst) begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
    end else if (if_req && d_req) begin
      if (prio_d) begin
        d_gnt = 1'b1;
      end else begin
        if_gnt = 1'b1;
      end
    end else begin
      if_gnt = if_req;
      d_gnt  = d_req;
    end
  end

  // Memory command mux; a misaligned data access is granted but never touches memory.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = 32'h0000_0000;
    if (d_gnt && !d_misal) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr[ADDR_W+1:2];
      mem_wdata = d_we ? d_wdata : 32'h0000_0000;
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr[ADDR_W+1:2];
    end else begin
      mem_en = 1'b0;
    end
  end

  // Pointer moves away from whichever port was just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_d <= 1'b1;
    end else if (d_gnt) begin
      prio_d <= 1'b0;
    end else if (if_gnt) begin
      prio_d <= 1'b1;
    end else begin
      prio_d <= prio_d;
    end
  end

  // Response ownership: at most one grant per cycle, so at most one pending flag is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_pend <= 1'b0;
      d_pend  <= 1'b0;
      d_load  <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      if_pend <= if_gnt;
      d_pend  <= d_gnt;
      d_load  <= d_gnt && !d_we && !d_misal;
      d_err_q <= d_gnt && d_misal;
    end
  end

  // Saturating count of cycles in which both ports competed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= 16'h0000;
    end else if (if_req && d_req && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'h0001;
    end else begin
      conflict_cnt <= conflict_cnt;
    end
  end

  assign if_rvalid = if_pend;
  assign if_rdata  = if_pend ? mem_rdata : 32'h0000_0000;
  assign d_rvalid  = d_pend;
  assign d_err     = d_err_q;
  assign d_rdata   = d_load ? mem_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a behavioural single-port memory.
module tb_riscv_mem_arbiter;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [15:0]       conflict_cnt;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int tests;
  int fails;

  riscv_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_if_gnt"}, {31'd0, if_gnt}, 32'd0);
    chk({tag, "_d_gnt"}, {31'd0, d_gnt}, 32'd0);
    chk({tag, "_if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
    chk({tag, "_d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
    chk({tag, "_d_err"}, {31'd0, d_err}, 32'd0);
    chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_cnt"}, {16'd0, conflict_cnt}, 32'd0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = v;
    #1;
    chk("st_gnt", {31'd0, d_gnt}, 32'd1);
    chk("st_mem_we", {31'd0, mem_we}, 32'd1);
    chk("st_mem_addr", {22'd0, mem_addr}, {22'd0, a[11:2]});
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
    chk("st_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("st_rdata", d_rdata, 32'd0);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_wdata = 32'h0;
    mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    all_zero("reset");
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;

    // Preload through the data port
    store(32'h8, 32'h00A18193);
    store(32'h20, 32'h11112222);

    // Fetch-only, plus ignored low bits and aliased high bits
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h8;
    #1;
    chk("f_gnt", {31'd0, if_gnt}, 32'd1);
    chk("f_dgnt", {31'd0, d_gnt}, 32'd0);
    chk("f_mem_en", {31'd0, mem_en}, 32'd1);
    chk("f_mem_addr", {22'd0, mem_addr}, 32'd2);
    @(posedge clk); #1;
    if_addr = 32'h0000_100B;
    chk("f_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("f_rdata", if_rdata, 32'h00A18193);
    chk("f_alias_addr", {22'd0, mem_addr}, 32'd2);
    @(posedge clk); #1;
    if_req = 1'b0;
    chk("f_alias_rdata", if_rdata, 32'h00A18193);
    @(posedge clk); #1;
    chk("f_idle_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("f_idle_mem_en", {31'd0, mem_en}, 32'd0);

    // Round-robin from a fresh reset: D,F,D,F
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_dgnt", {31'd0, d_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ifgnt", {31'd0, if_gnt}, (i % 2 == 0) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
      chk("rr_d_rvalid", {31'd0, d_rvalid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_if_rvalid", {31'd0, if_rvalid}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_rdata", (i % 2 == 0) ? d_rdata : if_rdata,
          (i % 2 == 0) ? 32'h11112222 : 32'h00A18193);
      chk("rr_cnt", {16'd0, conflict_cnt}, i + 1);
      @(negedge clk);
    end
    if_req = 1'b0; d_req = 1'b0;

    // Store then back-to-back load of the same word
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
    #1;
    chk("sl_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sl_mem_addr", {22'd0, mem_addr}, 32'd4);
    @(posedge clk); #1;
    d_we = 1'b0;
    chk("sl_st_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("sl_st_rdata", d_rdata, 32'd0);
    chk("sl_ld_gnt", {31'd0, d_gnt}, 32'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
    chk("sl_ld_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("sl_ld_rdata", d_rdata, 32'hDEADBEEF);
    chk("sl_ld_err", {31'd0, d_err}, 32'd0);

    // Misaligned load
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6;
    #1;
    chk("mis_gnt", {31'd0, d_gnt}, 32'd1);
    chk("mis_mem_en", {31'd0, mem_en}, 32'd0);
    @(posedge clk); #1;
    d_req = 1'b0;
    chk("mis_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("mis_err", {31'd0, d_err}, 32'd1);
    chk("mis_rdata", d_rdata, 32'd0);
    @(posedge clk); #1;
    chk("mis_err_clr", {31'd0, d_err}, 32'd0);

    // Reset during a pending fetch response
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h8;
    #1;
    chk("rp_gnt", {31'd0, if_gnt}, 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    chk("rp_rvalid_pre", {31'd0, if_rvalid}, 32'd1);
    rst = 1'b1;
    #1;
    all_zero("rp_in_reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rp_no_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rp_no_d_rvalid", {31'd0, d_rvalid}, 32'd0);

    // Conflict counter saturation
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", {16'd0, conflict_cnt}, 32'h0000FFFE);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("sat_ffff", {16'd0, conflict_cnt}, 32'h0000FFFF);
    end
    if_req = 1'b0; d_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
